uart_rx_controller: RTL

UART receive engine: the receive counterpart of the UART transmit controller. Oversamples the asynchronous `rx` line at 16x baud and detects and validates the start bit. It then shifts in 8 data bits LSB-first, checks optional parity and one or two stop bits, and pushes each completed byte into the RX queue with error flags. It sits between the `rx` pad and the RX FIFO inside the UART peripheral and shares the baud generator's oversample tick.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_bit_sync.sv | 25 ++
 rtl/uart_rx_controller.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states and default
// frame geometry used by the RX engine and its testbench.
package uart_pkg;

   localparam int UART_OVERSAMPLE    = 16;
   localparam int UART_DATA_BITS     = 8;
   localparam int UART_RX_MID_SAMPLE = UART_OVERSAMPLE / 2 - 1;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      STOP_2,
      BREAK
   } uart_rx_state_t;

endpackage

// File: rtl/uart_bit_sync.sv
// Two-flop synchronizer for asynchronous pad inputs (RX, CTS).
// Both flops come out of reset at RESET_VAL.
module uart_bit_sync #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   // Resolve metastability over two clk stages
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx_controller.sv
// UART receive engine: 16x oversampled start detect, LSB-first
// data, optional parity, 1/2 stop bits, commit to the RX FIFO.
module uart_rx_controller
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = UART_OVERSAMPLE,
   parameter int DATA_BITS  = UART_DATA_BITS
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rx_clk_en,
   input  logic                 rx,
   input  logic                 parity_en,
   input  logic                 parity_odd,
   input  logic                 double_stop_bit,
   input  logic                 rx_queue_full,
   output logic                 rx_queue_we,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_parity_err,
   output logic                 rx_frame_err,
   output logic                 rx_overrun_err,
   output logic                 rx_busy
);

   localparam int SW  = $clog2(OVERSAMPLE);
   localparam int BW  = $clog2(DATA_BITS) + 1;
   localparam int MID = OVERSAMPLE / 2 - 1;

   uart_rx_state_t state, state_nxt;

   logic                 rx_s;
   logic [SW-1:0]        samp;
   logic [BW-1:0]        bits;
   logic [DATA_BITS-1:0] shreg;
   logic                 acc, perr, ferr;
   logic                 cfg_pen, cfg_odd, cfg_dbl;
   logic                 samp_mid, samp_end, last_bit;
   logic                 commit, ferr_now;

   uart_bit_sync #(.RESET_VAL(1'b1)) u_rx_sync (
      .clk   (clk),
      .reset (reset),
      .d     (rx),
      .q     (rx_s)
   );

   assign samp_mid = (samp == SW'(MID));
   assign samp_end = (samp == SW'(OVERSAMPLE - 1));
   assign last_bit = (bits == BW'(DATA_BITS - 1));
   assign ferr_now = ferr | ~rx_s;
   assign commit   = rx_clk_en & samp_end &
                     (((state == STOP) & ~cfg_dbl) | (state == STOP_2));

   // Frame sequencing, advanced only on oversample ticks
   always_comb begin
      state_nxt = state;
      if (rx_clk_en) begin
         case (state)
            IDLE:    if (!rx_s) state_nxt = START;
            START:   if (samp_mid) state_nxt = rx_s ? IDLE : DATA;
            DATA:    if (samp_end && last_bit)
                        state_nxt = cfg_pen ? PARITY : STOP;
            PARITY:  if (samp_end) state_nxt = STOP;
            STOP:    if (samp_end)
                        state_nxt = cfg_dbl ? STOP_2 :
                                    (rx_s ? IDLE : BREAK);
            STOP_2:  if (samp_end) state_nxt = rx_s ? IDLE : BREAK;
            BREAK:   if (rx_s) state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // State register and registered busy flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         rx_busy <= 1'b0;
      end else begin
         state   <= state_nxt;
         rx_busy <= (state_nxt != IDLE);
      end
   end

   // Bit timing, shifting, error tracking and FIFO commit
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         samp           <= '0;
         bits           <= '0;
         shreg          <= '0;
         acc            <= 1'b0;
         perr           <= 1'b0;
         ferr           <= 1'b0;
         cfg_pen        <= 1'b0;
         cfg_odd        <= 1'b0;
         cfg_dbl        <= 1'b0;
         rx_queue_we    <= 1'b0;
         rx_data        <= '0;
         rx_parity_err  <= 1'b0;
         rx_frame_err   <= 1'b0;
         rx_overrun_err <= 1'b0;
      end else begin
         rx_queue_we    <= 1'b0;
         rx_parity_err  <= 1'b0;
         rx_frame_err   <= 1'b0;
         rx_overrun_err <= 1'b0;
         if (rx_clk_en) begin
            case (state)
               IDLE: samp <= '0;
               START: begin
                  if (samp_mid && !rx_s) begin
                     samp    <= '0;
                     bits    <= '0;
                     acc     <= 1'b0;
                     perr    <= 1'b0;
                     ferr    <= 1'b0;
                     cfg_pen <= parity_en;
                     cfg_odd <= parity_odd;
                     cfg_dbl <= double_stop_bit;
                  end else begin
                     samp <= samp + 1'b1;
                  end
               end
               DATA: begin
                  samp <= samp + 1'b1;
                  if (samp_end) begin
                     shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                     acc   <= acc ^ rx_s;
                     bits  <= bits + 1'b1;
                  end
               end
               PARITY: begin
                  samp <= samp + 1'b1;
                  if (samp_end) perr <= ((acc ^ rx_s) != cfg_odd);
               end
               STOP, STOP_2: begin
                  samp <= samp + 1'b1;
                  if (samp_end) ferr <= ferr_now;
               end
               default: ;
            endcase
            if (commit) begin
               if (!rx_queue_full) begin
                  rx_queue_we   <= 1'b1;
                  rx_data       <= shreg;
                  rx_parity_err <= perr;
                  rx_frame_err  <= ferr_now;
               end else begin
                  rx_overrun_err <= 1'b1;
               end
            end
         end
      end
   end

endmodule
